sram_writer: RTL and testbench
==============================

Name: sram_writer

Overview:
Downstream consumer of the FIFO-to-SRAM stage. Accepts the single-cycle sram_start/data strobe from that stage and writes each word into a circular buffer region of the DSP sample SRAM. The SRAM port uses a request/ready handshake. The block buffers words internally because the upstream stage has no backpressure. It generates addresses, wraps at the programmed buffer length, and reports frame completion and overflow.

Parameters:
dw, 32, data width of words and SRAM write data
aw, 10, SRAM word-address width

Ports:
wb_clk  input  1  system clock, all logic on rising edge
wb_rst  input  1  synchronous active-high reset
sram_start  input  1  one-cycle strobe: sram_data_in valid this cycle
sram_data_in  input  dw  word from the FIFO-to-SRAM stage
enable  input  1  when low, no new SRAM write is launched; captures still accepted
clear  input  1  synchronous soft clear of queue, offset and flags
base_addr  input  aw  first word address of the circular buffer
length  input  aw  buffer length in words; 0 means 2^aw
sram_req  output  1  write request to SRAM
sram_addr  output  aw  write address, valid while sram_req
sram_wdata  output  dw  write data, valid while sram_req
sram_ready  input  1  SRAM accepts the write in a cycle where sram_req=1 and sram_ready=1
busy  output  1  queue non-empty or write in flight
frame_done  output  1  one-cycle pulse after the write to the last buffer location completes
overflow  output  1  sticky: a word was dropped because the queue was full
word_count  output  aw  current offset within the buffer (next write location)

Behaviour:
- Reset (wb_rst=1): all outputs 0; queue emptied; offset 0; FSM in IDLE. wb_rst has priority over clear, and clear has priority over all other inputs.
- Queue: 2-entry FIFO of dw-bit words.
  - sram_start=1 with queue not full: push sram_data_in.
  - sram_start=1 with queue full: the word is dropped and overflow is set.
  - If a write completes (sram_req and sram_ready) in the same cycle, one slot is freed first, so a strobe to a full queue in that cycle is accepted. It does not overflow.
- FSM states: IDLE and WRITE.
  - IDLE -> WRITE on the next edge when the queue is non-empty (including the entry being pushed this cycle) and enable=1. The minimum latency from sram_start in cycle N to sram_req=1 is therefore cycle N+1.
  - In WRITE: sram_req=1, sram_wdata = queue head, sram_addr = base_l + offset, computed modulo 2^aw. All three outputs are registered and must remain stable until the handshake completes.
  - Handshake complete (sram_req and sram_ready in the same cycle): pop the head and advance the offset.
    - If the queue still holds a word and enable=1: stay in WRITE and present the next word on the next cycle (back-to-back, one write per cycle maximum).
    - Otherwise: go to IDLE and drop sram_req.
  - enable falling during WRITE does not abort the pending request. It only prevents the next launch.
- Offset and wrap:
  - The effective length L equals length, or 2^aw when length=0.
  - On completion, if offset == L-1: offset becomes 0 and frame_done=1 on the next cycle for exactly one cycle. Otherwise offset increments by 1.
  - word_count = offset.
- Latching: base_addr and length are latched into base_l/len_l whenever a write launches with offset=0. Changes at any other time take effect at the next wrap or clear.
- clear=1:
  - Queue emptied, offset 0, overflow 0, frame_done 0, FSM to IDLE, sram_req 0 next cycle.
  - A strobe in the same cycle is discarded.
  - A handshake in progress is abandoned. The SRAM treats deassertion of sram_req as cancel.
- busy = (queue non-empty) or sram_req.
- overflow remains set until clear or reset.

Test Plan:
1. Reset, base=0x100, length=4, enable=1, sram_ready tied 1. Send strobes with data 0xA0..0xA5, one every 2 cycles. Expect writes to 0x100,0x101,0x102,0x103,0x100,0x101. Expect a frame_done pulse one cycle after the 0x103 write. Final word_count=2.
2. sram_ready=0 for 10 cycles while 3 strobes arrive (0x11, 0x22, 0x33). Expect sram_req held with addr/wdata stable on 0x11. Expect the queue to hold 0x11 and 0x22, 0x33 dropped, and overflow=1. On ready, expect 0x11 then 0x22 written back-to-back.
3. Queue full, with a strobe arriving in the same cycle as a completing handshake. Expect no overflow, and the new word to be written next.
4. enable=0 while sending 2 strobes. Expect no sram_req and busy=1. Raise enable: expect sram_req on the next cycle and both words written.
5. length=0, aw=4, base=0xC. Write 17 words. Expect addresses 0xC..0xF, 0x0..0xB, 0xC. Expect frame_done after the 16th write.
6. Assert clear mid-WRITE with sram_ready=0 and overflow=1. Next cycle expect sram_req=0, overflow=0, word_count=0, busy=0. A strobe in the clear cycle is not written.

Source files
------------

// File: rtl/sram_writer.sv
// Circular-buffer SRAM writer: buffers strobed words in a 2-entry queue and
// writes them through a req/ready port, wrapping at the programmed length.
module sram_writer #(
    parameter int dw = 32,
    parameter int aw = 10
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          sram_start,
    input  logic [dw-1:0] sram_data_in,
    input  logic          enable,
    input  logic          clear,
    input  logic [aw-1:0] base_addr,
    input  logic [aw-1:0] length,
    output logic          sram_req,
    output logic [aw-1:0] sram_addr,
    output logic [dw-1:0] sram_wdata,
    input  logic          sram_ready,
    output logic          busy,
    output logic          frame_done,
    output logic          overflow,
    output logic [aw-1:0] word_count
);

    typedef enum logic {ST_IDLE, ST_WRITE} state_t;

    state_t        r_state;
    logic [dw-1:0] r_q0, r_q1;
    logic [1:0]    r_cnt;
    logic [aw-1:0] r_off, r_base_l, r_len_l;
    logic          r_req, r_done, r_ovf;
    logic [aw-1:0] r_addr;
    logic [dw-1:0] r_wdata;

    logic          w_done, w_push, w_wrap, w_launch;
    logic [1:0]    w_cnt_pop, w_cnt_n;
    logic [dw-1:0] w_q0_n, w_q1_n;
    logic [aw-1:0] w_off_n, w_base;

    // A completing write frees its slot before the incoming strobe is considered.
    always_comb begin
        w_done    = r_req & sram_ready;
        w_cnt_pop = r_cnt - {1'b0, w_done};
        w_push    = sram_start & (w_cnt_pop != 2'd2);
        w_q0_n    = w_done ? r_q1 : r_q0;
        w_q1_n    = r_q1;
        if (w_push) begin
            if (w_cnt_pop == 2'd0) w_q0_n = sram_data_in;
            else                   w_q1_n = sram_data_in;
        end
        w_cnt_n  = w_cnt_pop + {1'b0, w_push};
        // len_l of zero naturally yields an all-ones last offset, i.e. L = 2^aw.
        w_wrap   = (r_off == r_len_l - aw'(1));
        w_off_n  = w_done ? (w_wrap ? '0 : r_off + aw'(1)) : r_off;
        w_launch = enable & (w_cnt_n != 2'd0) & ((r_state == ST_IDLE) | w_done);
        w_base   = (w_off_n == '0) ? base_addr : r_base_l;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state  <= ST_IDLE;
            r_q0     <= '0;
            r_q1     <= '0;
            r_cnt    <= '0;
            r_off    <= '0;
            r_base_l <= '0;
            r_len_l  <= '0;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_off   <= '0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_q0   <= w_q0_n;
            r_q1   <= w_q1_n;
            r_cnt  <= w_cnt_n;
            r_off  <= w_off_n;
            r_done <= w_done & w_wrap;
            if (sram_start && !w_push) r_ovf <= 1'b1;
            if (w_launch) begin
                r_state <= ST_WRITE;
                r_req   <= 1'b1;
                r_addr  <= w_base + w_off_n;
                r_wdata <= w_q0_n;
                if (w_off_n == '0) begin
                    r_base_l <= base_addr;
                    r_len_l  <= length;
                end
            end else if (w_done) begin
                r_state <= ST_IDLE;
                r_req   <= 1'b0;
            end
        end
    end

    assign sram_req   = r_req;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign busy       = (r_cnt != 2'd0) | r_req;
    assign frame_done = r_done;
    assign overflow   = r_ovf;
    assign word_count = r_off;

endmodule

// File: tb/tb_sram_writer.sv
// Directed bench for sram_writer: default-width instance plus an aw=4 instance
// for the full 2^aw wrap case.
module tb_sram_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        wb_rst, sram_start, enable, clear, sram_ready;
    logic [31:0] sram_data_in, sram_wdata;
    logic [9:0]  base_addr, length, sram_addr, word_count;
    logic        sram_req, busy, frame_done, overflow;

    logic        rst4, start4, en4, clr4, rdy4;
    logic [31:0] din4, wdata4;
    logic [3:0]  base4, len4, addr4, wc4;
    logic        req4, busy4, fd4, ovf4;

    sram_writer dut (
        .wb_clk(clk), .wb_rst(wb_rst), .sram_start(sram_start), .sram_data_in(sram_data_in),
        .enable(enable), .clear(clear), .base_addr(base_addr), .length(length),
        .sram_req(sram_req), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_ready(sram_ready), .busy(busy), .frame_done(frame_done),
        .overflow(overflow), .word_count(word_count)
    );

    sram_writer #(.aw(4)) dut4 (
        .wb_clk(clk), .wb_rst(rst4), .sram_start(start4), .sram_data_in(din4),
        .enable(en4), .clear(clr4), .base_addr(base4), .length(len4),
        .sram_req(req4), .sram_addr(addr4), .sram_wdata(wdata4),
        .sram_ready(rdy4), .busy(busy4), .frame_done(fd4),
        .overflow(ovf4), .word_count(wc4)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [9:0]  wa[$];
    logic [31:0] wd[$];
    int          wcy[$];
    int          fdc[$];
    logic [3:0]  wa4[$];
    int          wcy4[$];
    int          fdc4[$];

    // Log every accepted write and every frame_done pulse with its cycle number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!wb_rst && !clear && sram_req && sram_ready) begin
            wa.push_back(sram_addr); wd.push_back(sram_wdata); wcy.push_back(cyc);
        end
        if (frame_done) fdc.push_back(cyc);
        if (!rst4 && !clr4 && req4 && rdy4) begin
            wa4.push_back(addr4); wcy4.push_back(cyc);
        end
        if (fd4) fdc4.push_back(cyc);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d);
        sram_start = 1'b1; sram_data_in = d;
        tick();
        sram_start = 1'b0;
    endtask

    task automatic soft_clear();
        clear = 1'b1; tick(); clear = 1'b0;
        wa.delete(); wd.delete(); wcy.delete(); fdc.delete();
    endtask

    task automatic test_reset();
        wb_rst = 1'b1; rst4 = 1'b1; tick(2);
        checks++; if ({sram_req, busy, frame_done, overflow} !== 4'b0) begin
            failures++; $display("FAIL rst_flags got=%b exp=0000", {sram_req, busy, frame_done, overflow}); end
        checks++; if (sram_addr !== 10'h0 || word_count !== 10'h0 || sram_wdata !== 32'h0) begin
            failures++; $display("FAIL rst_vals got=%h/%h/%h exp=0", sram_addr, word_count, sram_wdata); end
        checks++; if ({req4, busy4, fd4, ovf4} !== 4'b0 || wc4 !== 4'h0) begin
            failures++; $display("FAIL rst_dut4 got=%b/%h exp=0", {req4, busy4, fd4, ovf4}, wc4); end
        wb_rst = 1'b0; rst4 = 1'b0; tick();
    endtask

    task automatic test_wrap();
        logic [9:0] ea[6] = '{10'h100, 10'h101, 10'h102, 10'h103, 10'h100, 10'h101};
        base_addr = 10'h100; length = 10'd4; enable = 1'b1; sram_ready = 1'b1;
        soft_clear();
        for (int i = 0; i < 6; i++) begin
            strobe(32'hA0 + i);
            if (i == 0) begin
                checks++; if (sram_req !== 1'b1 || sram_addr !== 10'h100 || sram_wdata !== 32'hA0) begin
                    failures++; $display("FAIL wrap_latency got=%b/%h/%h exp=1/100/a0", sram_req, sram_addr, sram_wdata); end
            end
            tick();
        end
        tick(3);
        checks++; if (wa.size() !== 6) begin
            failures++; $display("FAIL wrap_count got=%0d exp=6", wa.size()); end
        for (int i = 0; i < 6 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== ea[i] || wd[i] !== 32'hA0 + i) begin
                failures++; $display("FAIL wrap_w%0d got=%h/%h exp=%h/%h", i, wa[i], wd[i], ea[i], 32'hA0 + i); end
        end
        checks++; if (fdc.size() !== 1 || wcy.size() < 4 || fdc[0] !== wcy[3] + 1) begin
            failures++; $display("FAIL wrap_frame_done got=%0d pulses exp=1 one cycle after 4th write", fdc.size()); end
        checks++; if (word_count !== 10'd2 || busy !== 1'b0) begin
            failures++; $display("FAIL wrap_word_count got=%0d/%b exp=2/0", word_count, busy); end
    endtask

    task automatic test_stall();
        soft_clear();
        sram_ready = 1'b0;
        strobe(32'h11);
        strobe(32'h22);
        checks++; if (overflow !== 1'b0) begin
            failures++; $display("FAIL stall_no_ovf got=%b exp=0", overflow); end
        strobe(32'h33);
        tick(7);
        checks++; if (sram_req !== 1'b1 || sram_addr !== 10'h100 || sram_wdata !== 32'h11) begin
            failures++; $display("FAIL stall_hold got=%b/%h/%h exp=1/100/11", sram_req, sram_addr, sram_wdata); end
        checks++; if (overflow !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL stall_ovf got=%b/%b exp=1/1", overflow, busy); end
        sram_ready = 1'b1;
        tick(4);
        checks++; if (wa.size() !== 2) begin
            failures++; $display("FAIL stall_count got=%0d exp=2", wa.size()); end
        else begin
            checks++; if (wd[0] !== 32'h11 || wd[1] !== 32'h22 || wa[0] !== 10'h100 || wa[1] !== 10'h101 || wcy[1] !== wcy[0] + 1) begin
                failures++; $display("FAIL stall_b2b got=%h@%h %h@%h exp=11@100 22@101 consecutive", wd[0], wa[0], wd[1], wa[1]); end
        end
    endtask

    task automatic test_full_simul();
        soft_clear();
        sram_ready = 1'b0;
        strobe(32'h51);
        strobe(32'h52);
        sram_ready = 1'b1;
        strobe(32'h53);
        tick(4);
        checks++; if (overflow !== 1'b0) begin
            failures++; $display("FAIL full_simul_ovf got=%b exp=0", overflow); end
        checks++; if (wd.size() !== 3) begin
            failures++; $display("FAIL full_simul_count got=%0d exp=3", wd.size()); end
        else begin
            checks++; if (wd[0] !== 32'h51 || wd[1] !== 32'h52 || wd[2] !== 32'h53 || wa[2] !== 10'h102) begin
                failures++; $display("FAIL full_simul_order got=%h %h %h@%h exp=51 52 53@102", wd[0], wd[1], wd[2], wa[2]); end
        end
    endtask

    task automatic test_enable();
        soft_clear();
        sram_ready = 1'b1; enable = 1'b0;
        strobe(32'h61);
        strobe(32'h62);
        tick(2);
        checks++; if (sram_req !== 1'b0 || busy !== 1'b1 || wa.size() !== 0) begin
            failures++; $display("FAIL enable_low got=%b/%b/%0d exp=0/1/0", sram_req, busy, wa.size()); end
        enable = 1'b1;
        tick();
        checks++; if (sram_req !== 1'b1 || sram_addr !== 10'h100 || sram_wdata !== 32'h61) begin
            failures++; $display("FAIL enable_launch got=%b/%h/%h exp=1/100/61", sram_req, sram_addr, sram_wdata); end
        tick(3);
        checks++; if (wd.size() !== 2 || busy !== 1'b0) begin
            failures++; $display("FAIL enable_count got=%0d/%b exp=2/0", wd.size(), busy); end
        else begin
            checks++; if (wd[0] !== 32'h61 || wd[1] !== 32'h62) begin
                failures++; $display("FAIL enable_data got=%h %h exp=61 62", wd[0], wd[1]); end
        end
    endtask

    task automatic test_full_range();
        base4 = 4'hC; len4 = 4'h0; en4 = 1'b1; rdy4 = 1'b1; clr4 = 1'b0;
        wa4.delete(); wcy4.delete(); fdc4.delete();
        for (int i = 0; i < 17; i++) begin
            start4 = 1'b1; din4 = 32'h100 + i; tick();
        end
        start4 = 1'b0;
        tick(3);
        checks++; if (wa4.size() !== 17) begin
            failures++; $display("FAIL range_count got=%0d exp=17", wa4.size()); end
        for (int i = 0; i < 17 && i < wa4.size(); i++) begin
            logic [3:0] exp_a;
            exp_a = 4'(12 + i);
            checks++; if (wa4[i] !== exp_a) begin
                failures++; $display("FAIL range_addr%0d got=%h exp=%h", i, wa4[i], exp_a); end
        end
        checks++; if (fdc4.size() !== 1 || wcy4.size() < 16 || fdc4[0] !== wcy4[15] + 1) begin
            failures++; $display("FAIL range_frame_done got=%0d pulses exp=1 after 16th write", fdc4.size()); end
        checks++; if (wc4 !== 4'd1 || ovf4 !== 1'b0) begin
            failures++; $display("FAIL range_word_count got=%0d/%b exp=1/0", wc4, ovf4); end
    endtask

    task automatic test_clear();
        soft_clear();
        sram_ready = 1'b1;
        strobe(32'h70);
        tick();
        sram_ready = 1'b0;
        strobe(32'h71);
        strobe(32'h72);
        strobe(32'h73);
        checks++; if (overflow !== 1'b1 || word_count !== 10'd1 || sram_req !== 1'b1) begin
            failures++; $display("FAIL clear_pre got=%b/%0d/%b exp=1/1/1", overflow, word_count, sram_req); end
        wa.delete(); wd.delete();
        clear = 1'b1; sram_start = 1'b1; sram_data_in = 32'h74;
        tick();
        clear = 1'b0; sram_start = 1'b0;
        checks++; if ({sram_req, overflow, busy, frame_done} !== 4'b0 || word_count !== 10'd0) begin
            failures++; $display("FAIL clear_post got=%b/%0d exp=0000/0", {sram_req, overflow, busy, frame_done}, word_count); end
        sram_ready = 1'b1;
        tick(4);
        checks++; if (wa.size() !== 0 || sram_req !== 1'b0) begin
            failures++; $display("FAIL clear_no_write got=%0d/%b exp=0/0", wa.size(), sram_req); end
    endtask

    initial begin
        wb_rst = 1'b1; sram_start = 1'b0; sram_data_in = '0; enable = 1'b1; clear = 1'b0;
        sram_ready = 1'b1; base_addr = 10'h100; length = 10'd4;
        rst4 = 1'b1; start4 = 1'b0; din4 = '0; en4 = 1'b1; clr4 = 1'b0; rdy4 = 1'b1;
        base4 = 4'hC; len4 = 4'h0;
        test_reset();
        test_wrap();
        test_stall();
        test_full_simul();
        test_enable();
        test_full_range();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
